// File: rtl/dmem_ctrl_if.sv
// Request/response bundle for one requester of the shared data memory.
// master = requester (core LSU, DMA); slave = dmem_ctrl.
interface dmem_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Round-robin two-port controller for a single-ported word-addressed data memory.
// Each accepted request runs IDLE -> ACCESS -> RESP; byte lanes and extension handled here.
module dmem_ctrl #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_ctrl_if.slave        p0,
  dmem_ctrl_if.slave        p1,
  output logic [ADDR_W-3:0] mem_adr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_data_in,
  output logic              mem_ld,
  output logic              mem_str,
  input  logic [31:0]       mem_data_out
);

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  function automatic logic access_err(input logic we, input logic [2:0] size,
                                      input logic [1:0] off);
    logic e;
    case (size)
      SZ_B:    e = 1'b0;
      SZ_H:    e = off[0];
      SZ_W:    e = (off != 2'b00);
      SZ_BU:   e = we;
      SZ_HU:   e = we | off[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size[1:0])
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] size, input logic [1:0] off,
                                              input logic [31:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    r = b;
      SZ_H:    r = h;
      SZ_BU:   r = {24'b0, b};
      SZ_HU:   r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_last_q, rr_last_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              win;
  logic              acc_err;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    we_d        = we_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    win         = 1'b0;
    p0.req_ready = 1'b0;
    p1.req_ready = 1'b0;
    mem_ld      = 1'b0;
    mem_str     = 1'b0;
    mem_we      = 4'b0000;
    acc_err     = access_err(we_q, size_q, addr_q[1:0]);

    case (state_q)
      IDLE: begin
        if (p0.req_valid || p1.req_valid) begin
          // On a tie the port that did not win last time goes first.
          win          = (p0.req_valid && p1.req_valid) ? ~rr_last_q : p1.req_valid;
          p0.req_ready = rst_n & ~win;
          p1.req_ready = rst_n & win;
          owner_d      = win;
          rr_last_d    = win;
          we_d         = win ? p1.req_we   : p0.req_we;
          size_d       = win ? p1.req_size : p0.req_size;
          addr_d       = win ? p1.req_addr : p0.req_addr;
          wdata_d      = replicate(size_d, win ? p1.req_wdata : p0.req_wdata);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (acc_err) begin
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (we_q) begin
          mem_str = 1'b1;
          mem_we  = byte_en(size_q, addr_q[1:0]);
          rdata_d = '0;
        end else begin
          mem_ld  = 1'b1;
          rdata_d = load_extend(size_q, addr_q[1:0], mem_data_out);
        end
        state_d = RESP;
      end
      RESP: begin
        if (owner_q ? p1.rsp_ready : p0.rsp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      we_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      we_q      <= we_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign mem_adr     = addr_q[ADDR_W-1:2];
  assign mem_data_in = wdata_q;

  assign p0.rsp_valid = (state_q == RESP) && !owner_q;
  assign p1.rsp_valid = (state_q == RESP) &&  owner_q;
  assign p0.rsp_rdata = p0.rsp_valid ? rdata_q : 32'd0;
  assign p1.rsp_rdata = p1.rsp_valid ? rdata_q : 32'd0;
  assign p0.rsp_err   = p0.rsp_valid & err_q;
  assign p1.rsp_err   = p1.rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table of single transactions plus
// hand sequences for reset abort, round-robin fairness and response back-pressure.
module tb_dmem_ctrl;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(14)) p0_if ();
  dmem_ctrl_if #(.ADDR_W(14)) p1_if ();

  logic [11:0] mem_adr;
  logic [3:0]  mem_we;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ld;
  logic        mem_str;

  dmem_ctrl #(.ADDR_W(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0           (p0_if),
    .p1           (p1_if),
    .mem_adr      (mem_adr),
    .mem_we       (mem_we),
    .mem_data_in  (mem_data_in),
    .mem_ld       (mem_ld),
    .mem_str      (mem_str),
    .mem_data_out (mem_data_out)
  );

  logic [31:0] tb_mem [4096];
  assign mem_data_out = tb_mem[mem_adr];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= 32'd0;
    end else if (mem_str) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) tb_mem[mem_adr][8*b +: 8] <= mem_data_in[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input bit p);
    return p ? p1_if.req_ready : p0_if.req_ready;
  endfunction
  function automatic logic rv(input bit p);
    return p ? p1_if.rsp_valid : p0_if.rsp_valid;
  endfunction
  function automatic logic [31:0] rd(input bit p);
    return p ? p1_if.rsp_rdata : p0_if.rsp_rdata;
  endfunction
  function automatic logic er(input bit p);
    return p ? p1_if.rsp_err : p0_if.rsp_err;
  endfunction

  task automatic drive(input bit p, input logic v, input logic we, input logic [2:0] size,
                       input logic [13:0] addr, input logic [31:0] wdata);
    if (p) begin
      p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_size = size;
      p1_if.req_addr = addr; p1_if.req_wdata = wdata;
    end else begin
      p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_size = size;
      p0_if.req_addr = addr; p0_if.req_wdata = wdata;
    end
  endtask

  task automatic set_rr(input bit p, input logic v);
    if (p) p1_if.rsp_ready = v;
    else   p0_if.rsp_ready = v;
  endtask

  typedef struct {
    bit          port;
    logic        we;
    logic [2:0]  size;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  mwe;
    logic [31:0] din;
    bit          din_chk;
  } vec_t;

  vec_t vecs [22];

  task automatic run_txn(input vec_t v, input int idx);
    logic exp_str, exp_ld;
    exp_str = v.we & ~v.err;
    exp_ld  = ~v.we & ~v.err;
    @(negedge clk);
    drive(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
    #1;
    chk($sformatf("v%0d req_ready", idx), 32'(rdy(v.port)), 32'd1);
    chk($sformatf("v%0d other_ready", idx), 32'(rdy(~v.port)), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(v.port, 1'b0, 1'b0, 3'b000, 14'd0, 32'd0);
    #1;
    chk($sformatf("v%0d mem_adr", idx), 32'(mem_adr), 32'(v.addr[13:2]));
    chk($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(v.mwe));
    chk($sformatf("v%0d mem_str", idx), 32'(mem_str), 32'(exp_str));
    chk($sformatf("v%0d mem_ld", idx), 32'(mem_ld), 32'(exp_ld));
    if (v.din_chk) chk($sformatf("v%0d mem_data_in", idx), mem_data_in, v.din);
    chk($sformatf("v%0d early_rsp", idx), 32'(rv(v.port)), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d rsp_valid", idx), 32'(rv(v.port)), 32'd1);
    chk($sformatf("v%0d rsp_rdata", idx), rd(v.port), v.rdata);
    chk($sformatf("v%0d rsp_err", idx), 32'(er(v.port)), 32'(v.err));
    chk($sformatf("v%0d other_rsp", idx), 32'(rv(~v.port)), 32'd0);
    set_rr(v.port, 1'b1);
    @(posedge clk);
    #1;
    set_rr(v.port, 1'b0);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d rsp_clear", idx), {31'd0, rv(v.port)}, 32'd0);
  endtask

  initial begin
    int   grants;
    int   cyc;
    logic last;
    logic g;
    vec_t t;

    p0_if.req_valid = 1'b0; p0_if.req_we = 1'b0; p0_if.req_size = 3'b0;
    p0_if.req_addr = 14'd0; p0_if.req_wdata = 32'd0; p0_if.rsp_ready = 1'b0;
    p1_if.req_valid = 1'b0; p1_if.req_we = 1'b0; p1_if.req_size = 3'b0;
    p1_if.req_addr = 14'd0; p1_if.req_wdata = 32'd0; p1_if.rsp_ready = 1'b0;

    //            port we size addr     wdata         rdata         err  mwe      din           din_chk
    vecs[0]  = '{0, 1, W,  14'h008, 32'hDEADBEEF, 32'h00000000, 0, 4'b1111, 32'hDEADBEEF, 1};
    vecs[1]  = '{0, 0, W,  14'h008, 32'h00000000, 32'hDEADBEEF, 0, 4'b0000, 32'h0,        0};
    vecs[2]  = '{0, 1, B,  14'h00D, 32'h0000005A, 32'h00000000, 0, 4'b0010, 32'h5A5A5A5A, 1};
    vecs[3]  = '{0, 0, B,  14'h00D, 32'h00000000, 32'h0000005A, 0, 4'b0000, 32'h0,        0};
    vecs[4]  = '{0, 1, B,  14'h00E, 32'h00000080, 32'h00000000, 0, 4'b0100, 32'h80808080, 1};
    vecs[5]  = '{0, 0, B,  14'h00E, 32'h00000000, 32'hFFFFFF80, 0, 4'b0000, 32'h0,        0};
    vecs[6]  = '{0, 0, BU, 14'h00E, 32'h00000000, 32'h00000080, 0, 4'b0000, 32'h0,        0};
    vecs[7]  = '{0, 1, H,  14'h012, 32'h00008001, 32'h00000000, 0, 4'b1100, 32'h80018001, 1};
    vecs[8]  = '{0, 0, H,  14'h012, 32'h00000000, 32'hFFFF8001, 0, 4'b0000, 32'h0,        0};
    vecs[9]  = '{0, 0, HU, 14'h012, 32'h00000000, 32'h00008001, 0, 4'b0000, 32'h0,        0};
    vecs[10] = '{0, 0, W,  14'h006, 32'h00000000, 32'h00000000, 1, 4'b0000, 32'h0,        0};
    vecs[11] = '{0, 1, H,  14'h003, 32'h0000FFFF, 32'h00000000, 1, 4'b0000, 32'h0,        0};
    vecs[12] = '{0, 1, BU, 14'h008, 32'h11111111, 32'h00000000, 1, 4'b0000, 32'h0,        0};
    vecs[13] = '{0, 1, HU, 14'h008, 32'h22222222, 32'h00000000, 1, 4'b0000, 32'h0,        0};
    vecs[14] = '{0, 0, 3'b011, 14'h008, 32'h0,    32'h00000000, 1, 4'b0000, 32'h0,        0};
    vecs[15] = '{1, 0, 3'b110, 14'h008, 32'h0,    32'h00000000, 1, 4'b0000, 32'h0,        0};
    vecs[16] = '{1, 1, 3'b111, 14'h008, 32'h33333333, 32'h0,    1, 4'b0000, 32'h0,        0};
    vecs[17] = '{0, 0, W,  14'h008, 32'h00000000, 32'hDEADBEEF, 0, 4'b0000, 32'h0,        0};
    vecs[18] = '{0, 0, W,  14'h00C, 32'h00000000, 32'h00805A00, 0, 4'b0000, 32'h0,        0};
    vecs[19] = '{1, 0, W,  14'h010, 32'h00000000, 32'h80010000, 0, 4'b0000, 32'h0,        0};
    vecs[20] = '{1, 0, H,  14'h012, 32'h00000000, 32'hFFFF8001, 0, 4'b0000, 32'h0,        0};
    vecs[21] = '{1, 1, B,  14'h003, 32'h000000C3, 32'h00000000, 0, 4'b1000, 32'hC3C3C3C3, 1};

    repeat (2) @(negedge clk);
    #1;
    chk("rst mem_str", 32'(mem_str), 32'd0);
    chk("rst mem_ld", 32'(mem_ld), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_adr", 32'(mem_adr), 32'd0);
    chk("rst mem_data_in", mem_data_in, 32'd0);
    chk("rst rsp_valid", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clr   = 1'b0;

    for (int i = 0; i < 22; i++) run_txn(vecs[i], i);

    // Reset asserted while a store sits in ACCESS.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, W, 14'h020, 32'hCAFEF00D);
    #1;
    chk("abort req_ready", 32'(p0_if.req_ready), 32'd1);
    @(negedge clk);
    #1;
    chk("abort pre mem_str", 32'(mem_str), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_str", 32'(mem_str), 32'd0);
    chk("abort mem_we", 32'(mem_we), 32'd0);
    chk("abort mem_adr", 32'(mem_adr), 32'd0);
    chk("abort mem_data_in", mem_data_in, 32'd0);
    chk("abort req_ready", 32'(p0_if.req_ready), 32'd0);
    drive(0, 1'b0, 1'b0, 3'b000, 14'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      chk("abort rsp_valid", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;

    // Both ports continuously valid: grants must alternate starting with port 0.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, W, 14'h008, 32'd0);
    drive(1, 1'b1, 1'b0, W, 14'h010, 32'd0);
    set_rr(0, 1'b1);
    set_rr(1, 1'b1);
    grants = 0;
    cyc    = 0;
    last   = 1'b0;
    while (grants < 6 && cyc < 60) begin
      #1;
      if (p0_if.rsp_valid || p1_if.rsp_valid) begin
        chk("fair rsp owner", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, last ? 32'd2 : 32'd1);
        chk("fair rsp rdata", last ? p1_if.rsp_rdata : p0_if.rsp_rdata,
            last ? 32'h80010000 : 32'hDEADBEEF);
      end
      if (p0_if.req_ready || p1_if.req_ready) begin
        chk("fair single grant", 32'(p0_if.req_ready & p1_if.req_ready), 32'd0);
        g = p1_if.req_ready;
        chk($sformatf("fair grant%0d", grants), 32'(g), 32'(grants % 2));
        last = g;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    if (grants < 6) chk("fair timeout grants", 32'(grants), 32'd6);
    drive(0, 1'b0, 1'b0, 3'b000, 14'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 14'd0, 32'd0);
    @(negedge clk);
    #1;
    chk("fair last rsp", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'd2);
    @(negedge clk);
    set_rr(0, 1'b0);
    set_rr(1, 1'b0);
    @(negedge clk);

    // Response back-pressure with port 1 waiting.
    drive(0, 1'b1, 1'b0, W, 14'h008, 32'd0);
    #1;
    chk("bp p0 ready", 32'(p0_if.req_ready), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 3'b000, 14'd0, 32'd0);
    drive(1, 1'b1, 1'b0, W, 14'h010, 32'd0);
    #1;
    chk("bp p1 ready in access", 32'(p1_if.req_ready), 32'd0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp rsp_valid held", 32'(p0_if.rsp_valid), 32'd1);
      chk("bp rdata held", p0_if.rsp_rdata, 32'hDEADBEEF);
      chk("bp no grant", 32'(p1_if.req_ready), 32'd0);
      @(negedge clk);
    end
    set_rr(0, 1'b1);
    #1;
    chk("bp no grant on rsp_ready", 32'(p1_if.req_ready), 32'd0);
    @(negedge clk);
    set_rr(0, 1'b0);
    #1;
    chk("bp rsp cleared", 32'(p0_if.rsp_valid), 32'd0);
    chk("bp rdata cleared", p0_if.rsp_rdata, 32'd0);
    chk("bp p1 granted", 32'(p1_if.req_ready), 32'd1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 3'b000, 14'd0, 32'd0);
    #1;
    chk("bp p1 mem_ld", 32'(mem_ld), 32'd1);
    chk("bp p1 mem_adr", 32'(mem_adr), 32'd4);
    @(negedge clk);
    #1;
    chk("bp p1 rsp", {30'd0, p1_if.rsp_valid, p0_if.rsp_valid}, 32'd2);
    chk("bp p1 rdata", p1_if.rsp_rdata, 32'h80010000);
    set_rr(1, 1'b1);
    @(negedge clk);
    set_rr(1, 1'b0);

    // The aborted store must not have reached memory.
    t = '{0, 0, W, 14'h020, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0, 0};
    run_txn(t, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Two-port controller that shares the single-ported word-addressed data memory between port 0 (core load/store unit) and port 1 (DMA/debug loader).
- Round-robin arbitration; each accepted request goes through a 3-state sequence.
- Converts byte addresses plus RV32I funct3 size codes into the memory word address, byte write enables, lane-replicated write data, and sign/zero-extended load data.
- Detects misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_W, 14, byte-address width; the memory word address is addr[ADDR_W-1:2] (12 bits at default).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- p0_req_valid  in  1  port 0 request valid.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_we  in  1  1 = store, 0 = load.
- p0_req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- p0_req_addr  in  ADDR_W  byte address.
- p0_req_wdata  in  32  store data, right-aligned.
- p0_rsp_valid  out  1  port 0 response valid.
- p0_rsp_ready  in  1  port 0 response consumed.
- p0_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- p0_rsp_err  out  1  misaligned or illegal access.
- p1_*  same set as p0_*, for port 1.
- mem_adr  out  12  memory word address.
- mem_we  out  4  byte write enables.
- mem_data_in  out  32  memory write data.
- mem_ld  out  1  memory load strobe.
- mem_str  out  1  memory store strobe.
- mem_data_out  in  32  memory read data; combinational, valid while mem_ld=1.

Behaviour:
- States: IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs 0; rr_last=1, so port 0 wins the first tie.
- IDLE:
  - Winner = the only valid port; if both are valid, the port != rr_last.
  - Winner's req_ready=1 combinationally in this cycle only.
  - At the edge: latch we/size/addr/wdata/owner, set rr_last=winner, go to ACCESS.
  - No valid requests: stay in IDLE; req_ready=0 on both ports.
- ACCESS (1 cycle):
  - mem_adr = latched addr[ADDR_W-1:2]; off = addr[1:0].
  - Store: mem_str=1.
    - B: mem_we = 1<<off; data = byte replicated on all 4 lanes.
    - H: mem_we = 0011 (off=0) or 1100 (off=2); data = halfword replicated.
    - W: mem_we = 1111.
  - Load: mem_ld=1, mem_we=0.
    - Capture at edge: B/BU take the byte at lane off; H/HU take the half at lane off[1].
    - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Error cases:
    - Misaligned: H/HU with off[0]=1; W with off!=0.
    - Illegal size: 011, 110, 111; store with 100 or 101.
    - On error: mem_ld=mem_str=0, mem_we=0, rdata=0, err latched as 1.
  - Go to RESP.
  - In IDLE and RESP: mem_ld=mem_str=0, mem_we=0. mem_adr and mem_data_in hold their last value.
- RESP:
  - Owner's rsp_valid=1; rdata/err stable until rsp_ready=1.
  - On valid&&ready: go to IDLE; rsp_valid, rdata and err clear on the next cycle.
  - The non-owner's rsp_valid stays 0 throughout.
- Latency and throughput:
  - Minimum 3 cycles from acceptance to IDLE.
  - rsp_valid is asserted 2 cycles after the req_ready cycle.
  - One outstanding request total.
- Requests arriving outside IDLE are not accepted (ready=0); they must be held by the requester.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1…
- Simultaneous events: a new request in the rsp_ready cycle is accepted in the next IDLE cycle, not the same one.
- Reset mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - An in-flight store is aborted if reset asserts during ACCESS before the edge; no response is ever issued for it.

Test Plan:
- Port 0 SW addr 0x008, wdata 0xDEADBEEF, then LW 0x008 -> ACCESS shows mem_adr=2, mem_we=1111; load response rdata=0xDEADBEEF, err=0, rsp_valid 2 cycles after accept.
- Port 0 SB 0x00D data 0x5A, then LB 0x00D -> mem_we=0010, mem_data_in=0x5A5A5A5A; LB returns 0x0000005A. SB 0x00E 0x80 then LB/LBU 0x00E -> 0xFFFFFF80 / 0x00000080.
- SH 0x012 data 0x8001, then LH/LHU 0x012 -> mem_we=1100; LH returns 0xFFFF8001, LHU returns 0x00008001.
- LW 0x006, SH 0x003, store size 100 -> rsp_err=1, rdata=0, mem_str=mem_ld=0 during ACCESS; memory contents unchanged on readback.
- Both ports valid continuously for 6 requests -> grants in order 0,1,0,1,0,1; p1_rsp_valid never asserted for a port-0 transaction. Hold rsp_ready=0 for 5 cycles -> rsp held stable and no new grant.
- Assert rst_n=0 during ACCESS of SW 0x020 -> outputs 0 immediately, state IDLE, no rsp_valid. After release, a tie grants port 0 first.
